einstein_intc: RTL and testbench

Parametrised, prioritised interrupt controller for the Einstein core. It generalises the single keyboard interrupt/mask flip-flop pair and the vector mux into NCH maskable channels. Channels can be edge- or level-triggered, with Z80 mode-2 vector generation, in-service tracking cleared by RETI, and a daisy-chain IEI/IEO. It sits between the peripheral request sources (keyboard, ADC, fire button, …) and the T80 INT_n/data-bus mux, ahead of the CTC in the daisy chain.

---
 rtl/einstein_pkg.sv | 32 +++
 rtl/einstein_intc_if.sv | 30 +++
 rtl/einstein_intc_chan.sv | 51 +++++
 rtl/einstein_intc.sv | 116 +++++++++++
 tb/tb_einstein_intc.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/einstein_pkg.sv
// Shared types and helpers for the Einstein interrupt controller.
package einstein_pkg;

    localparam int unsigned MAX_CH   = 8;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned VEC_W    = 8;
    localparam int unsigned VEC_STEP = 2;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } prio_t;

    // Lowest set bit wins; valid is low for an all-zero vector.
    function automatic prio_t prio_enc(input logic [MAX_CH-1:0] v);
        prio_t r;
        r = '0;
        for (int i = int'(MAX_CH) - 1; i >= 0; i--) begin
            if (v[i]) begin
                r.valid = 1'b1;
                r.idx   = IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/einstein_intc_if.sv
// Request, mask, acknowledge and daisy-chain signals of the interrupt controller.
interface einstein_intc_if
    import einstein_pkg::*;
#(
    parameter int unsigned NCH = 4
);
    logic [NCH-1:0]   src;
    logic [NCH-1:0]   msk_we;
    logic             msk_din;
    logic [NCH-1:0]   clr;
    logic             m1_n;
    logic             iorq_n;
    logic             reti;
    logic             iei;
    logic             int_n;
    logic [VEC_W-1:0] vec;
    logic             vec_oe;
    logic             ieo;
    logic [NCH-1:0]   pend;

    modport master (
        output src, msk_we, msk_din, clr, m1_n, iorq_n, reti, iei,
        input  int_n, vec, vec_oe, ieo, pend
    );

    modport slave (
        input  src, msk_we, msk_din, clr, m1_n, iorq_n, reti, iei,
        output int_n, vec, vec_oe, ieo, pend
    );
endinterface

// File: rtl/einstein_intc_chan.sv
// One interrupt channel: input synchroniser, edge/level event, mask and pending flag.
module einstein_intc_chan #(
    parameter bit          EDGE = 1'b1,
    parameter int unsigned SYNC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic src,
    input  logic msk_we,
    input  logic msk_din,
    input  logic clr,
    input  logic take,
    output logic pend
);

    logic s;
    logic hist;
    logic mask;
    logic ev_c;

    if (SYNC == 0) begin : g_nosync
        assign s = src;
    end else begin : g_sync
        logic [SYNC-1:0] sr;

        // Shift src through SYNC flops before it is used.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) sr <= '0;
            else        sr <= SYNC'({sr, src});
        end

        assign s = sr[SYNC-1];
    end

    assign ev_c = EDGE ? (s & ~hist) : s;

    // Edge history, mask (reset to disabled) and pending; clear or acknowledge beats a new event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= 1'b0;
            mask <= 1'b1;
            pend <= 1'b0;
        end else begin
            hist <= s;
            if (msk_we) mask <= msk_din;
            if (clr || take)      pend <= 1'b0;
            else if (ev_c && !mask) pend <= 1'b1;
        end
    end

endmodule

// File: rtl/einstein_intc.sv
// Prioritised Z80 mode-2 interrupt controller with in-service tracking and IEI/IEO chaining.
module einstein_intc
    import einstein_pkg::*;
#(
    parameter int unsigned      NCH      = 4,
    parameter logic [VEC_W-1:0] VEC_BASE = 8'h0E,
    parameter logic [NCH-1:0]   EDGE     = '1,
    parameter int unsigned      SYNC     = 2
) (
    input  logic           clk_sys,
    input  logic           reset_n,
    einstein_intc_if.slave bus
);

    state_t           state, state_d;
    logic [NCH-1:0]   pend_c, take_c, qual_c, hi_mask_c, reti_clr_c;
    logic [NCH-1:0]   isv, isv_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic             vec_oe_q, vec_oe_d;
    logic             int_n_q, int_n_d;
    logic             ack_q, ack_c, ack_rise_c;
    prio_t            isv_lo_c, win_c;

    for (genvar c = 0; c < int'(NCH); c++) begin : g_chan
        einstein_intc_chan #(
            .EDGE (EDGE[c]),
            .SYNC (SYNC)
        ) u_chan (
            .clk     (clk_sys),
            .rst_n   (reset_n),
            .src     (bus.src[c]),
            .msk_we  (bus.msk_we[c]),
            .msk_din (bus.msk_din),
            .clr     (bus.clr[c]),
            .take    (take_c[c]),
            .pend    (pend_c[c])
        );
    end

    assign ack_c      = ~bus.m1_n & ~bus.iorq_n;
    assign ack_rise_c = ack_c & ~ack_q;

    // Qualify pending channels that outrank every in-service channel, then pick the winner.
    always_comb begin
        isv_lo_c  = prio_enc(MAX_CH'(isv));
        hi_mask_c = '0;
        for (int c = 0; c < int'(NCH); c++) begin
            hi_mask_c[c] = !isv_lo_c.valid || (IDX_W'(c) < isv_lo_c.idx);
        end
        qual_c = pend_c & hi_mask_c;
        win_c  = prio_enc(MAX_CH'(qual_c));
    end

    // Acknowledge FSM: latch the winner on the first ack cycle, drive the bus until ack ends.
    always_comb begin
        state_d  = state;
        vec_d    = vec_q;
        vec_oe_d = 1'b0;
        int_n_d  = 1'b1;
        take_c   = '0;
        unique case (state)
            IDLE: begin
                if (ack_rise_c && bus.iei && win_c.valid) begin
                    state_d  = ACK;
                    take_c   = NCH'(1) << win_c.idx;
                    vec_d    = VEC_BASE + VEC_W'(VEC_STEP * win_c.idx);
                    vec_oe_d = 1'b1;
                end else begin
                    int_n_d = ~(bus.iei & (|qual_c));
                end
            end
            ACK: begin
                if (ack_c) begin
                    vec_oe_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    int_n_d = ~(bus.iei & (|qual_c));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // RETI retires the highest-priority in-service channel; an ack marks the new one.
    always_comb begin
        reti_clr_c = '0;
        if (bus.reti && isv_lo_c.valid) reti_clr_c = NCH'(1) << isv_lo_c.idx;
        isv_d = (isv & ~reti_clr_c) | take_c;
    end

    // State, in-service and registered CPU-facing outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            isv      <= '0;
            ack_q    <= 1'b0;
            vec_q    <= 8'h00;
            vec_oe_q <= 1'b0;
            int_n_q  <= 1'b1;
        end else begin
            state    <= state_d;
            isv      <= isv_d;
            ack_q    <= ack_c;
            vec_q    <= vec_d;
            vec_oe_q <= vec_oe_d;
            int_n_q  <= int_n_d;
        end
    end

    assign bus.int_n  = int_n_q;
    assign bus.vec    = vec_q;
    assign bus.vec_oe = vec_oe_q;
    assign bus.pend   = pend_c;
    assign bus.ieo    = bus.iei & ~(|isv) & ~(|pend_c);

endmodule

// File: tb/tb_einstein_intc.sv
// Bench for einstein_intc: directed scenarios plus random traffic against a behavioural model.
module tb_einstein_intc;

    localparam int         NCH      = 4;
    localparam logic [7:0] VEC_BASE = 8'h0E;
    localparam logic [3:0] EDGE     = 4'b0111;
    localparam int         SYNC     = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    einstein_intc_if #(.NCH(NCH)) bus ();

    einstein_intc #(
        .NCH      (NCH),
        .VEC_BASE (VEC_BASE),
        .EDGE     (EDGE),
        .SYNC     (SYNC)
    ) u_dut (
        .clk_sys (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    logic [NCH-1:0] past [1:SYNC+1];   // past[k] = src sampled k clocks ago
    logic [NCH-1:0] m_mask, m_pend, m_isv;
    logic           m_in_ack, m_ack_prev, m_int_n, m_vec_oe;
    logic [7:0]     m_vec;

    logic [NCH-1:0] s_now, s_prev, ev, qual, n_pend, n_mask, n_isv;
    logic           ack, take, n_in_ack, n_int_n, m_ieo;
    logic [7:0]     n_vec;
    int             li, w;

    always_comb begin
        s_now  = past[SYNC];
        s_prev = past[SYNC+1];
        li = NCH;
        for (int c = NCH - 1; c >= 0; c--) if (m_isv[c]) li = c;
        qual = '0;
        for (int c = 0; c < NCH; c++) qual[c] = m_pend[c] && (c < li);
        w = -1;
        for (int c = NCH - 1; c >= 0; c--) if (qual[c]) w = c;
        ack  = !bus.m1_n && !bus.iorq_n;
        take = !m_in_ack && ack && !m_ack_prev && bus.iei && (w >= 0);
        n_pend = m_pend;
        n_mask = m_mask;
        ev     = '0;
        for (int c = 0; c < NCH; c++) begin
            ev[c] = EDGE[c] ? (s_now[c] && !s_prev[c]) : s_now[c];
            if (bus.clr[c])               n_pend[c] = 1'b0;
            else if (take && c == w)      n_pend[c] = 1'b0;
            else if (ev[c] && !m_mask[c]) n_pend[c] = 1'b1;
            if (bus.msk_we[c]) n_mask[c] = bus.msk_din;
        end
        n_isv = m_isv;
        if (bus.reti && li < NCH) n_isv = n_isv & ~(4'(1) << li);
        if (take)                 n_isv = n_isv | (4'(1) << w);
        n_in_ack = m_in_ack ? ack : take;
        n_vec    = take ? 8'(VEC_BASE + 8'(2 * w)) : m_vec;
        n_int_n  = n_in_ack ? 1'b1 : !(bus.iei && (qual != '0));
        m_ieo    = bus.iei && (m_isv == '0) && (m_pend == '0);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= SYNC + 1; k++) past[k] <= '0;
            m_mask     <= '1;
            m_pend     <= '0;
            m_isv      <= '0;
            m_in_ack   <= 1'b0;
            m_ack_prev <= 1'b0;
            m_int_n    <= 1'b1;
            m_vec      <= 8'h00;
            m_vec_oe   <= 1'b0;
        end else begin
            past[1] <= bus.src;
            for (int k = 2; k <= SYNC + 1; k++) past[k] <= past[k-1];
            m_mask     <= n_mask;
            m_pend     <= n_pend;
            m_isv      <= n_isv;
            m_in_ack   <= n_in_ack;
            m_ack_prev <= ack;
            m_int_n    <= n_int_n;
            m_vec      <= n_vec;
            m_vec_oe   <= n_in_ack;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_int_n",  32'(bus.int_n),  32'(m_int_n));
            check("cyc_vec_oe", 32'(bus.vec_oe), 32'(m_vec_oe));
            check("cyc_vec",    32'(bus.vec),    32'(m_vec));
            check("cyc_pend",   32'(bus.pend),   32'(m_pend));
            check("cyc_ieo",    32'(bus.ieo),    32'(m_ieo));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_src(input logic [NCH-1:0] m);
        bus.src = m;
        tick();
        bus.src = '0;
    endtask

    task automatic set_mask(input int c, input logic v);
        bus.msk_we  = 4'(1) << c;
        bus.msk_din = v;
        tick();
        bus.msk_we  = '0;
        bus.msk_din = 1'b0;
    endtask

    task automatic reti_pulse();
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
    endtask

    task automatic wait_int(input string name);
        int n;
        n = 0;
        while (bus.int_n !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        check(name, 32'(bus.int_n), 32'(0));
    endtask

    task automatic ack_cycle(input logic [7:0] exp_vec, input logic exp_oe, input string name);
        bus.m1_n   = 1'b0;
        bus.iorq_n = 1'b0;
        tick();
        check({name, "_oe"}, 32'(bus.vec_oe), 32'(exp_oe));
        if (exp_oe) check({name, "_vec"}, 32'(bus.vec), 32'(exp_vec));
        check({name, "_int_n"}, 32'(bus.int_n), 32'(1));
        tick();
        tick();
        bus.m1_n   = 1'b1;
        bus.iorq_n = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_cnt;
        bus.src = '0; bus.msk_we = '0; bus.msk_din = 1'b0; bus.clr = '0;
        bus.m1_n = 1'b1; bus.iorq_n = 1'b1; bus.reti = 1'b0; bus.iei = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_int_n",  32'(bus.int_n),  32'(1));
        check("rst_vec",    32'(bus.vec),    32'(8'h00));
        check("rst_vec_oe", 32'(bus.vec_oe), 32'(0));
        check("rst_pend",   32'(bus.pend),   32'(0));
        check("rst_ieo",    32'(bus.ieo),    32'(1));
        rst_n = 1'b1;
        tick();

        // Masks come out of reset disabled.
        pulse_src(4'b1111);
        repeat (6) tick();
        check("rst_mask_pend",  32'(bus.pend),  32'(0));
        check("rst_mask_int_n", 32'(bus.int_n), 32'(1));
        for (int c = 0; c < NCH; c++) set_mask(c, 1'b0);

        // Edge request latency and vector.
        begin
            int lat;
            bus.src = 4'b0010;
            lat = 0;
            do begin
                tick();
                lat++;
                bus.src = '0;
            end while (bus.int_n !== 1'b0 && lat < 20);
            check("latency", 32'(lat), 32'(SYNC + 2));
        end
        ack_cycle(8'h10, 1'b1, "ack_ch1");
        check("ack_ch1_pend", 32'(bus.pend[1]), 32'(0));
        reti_pulse();
        tick();
        check("ch1_reti_ieo", 32'(bus.ieo), 32'(1));

        // Priority between simultaneous requests.
        pulse_src(4'b0101);
        wait_int("prio_int");
        ack_cycle(8'h0E, 1'b1, "prio_first");
        check("prio_wait", 32'(bus.int_n), 32'(1));
        reti_pulse();
        wait_int("prio_int2");
        ack_cycle(8'h12, 1'b1, "prio_second");
        reti_pulse();

        // Nesting: higher priority pre-empts, lower waits for RETI.
        pulse_src(4'b0100);
        wait_int("nest_int");
        ack_cycle(8'h12, 1'b1, "nest_ch2");
        pulse_src(4'b0001);
        wait_int("nest_ch0_int");
        ack_cycle(8'h0E, 1'b1, "nest_ch0");
        reti_pulse();
        pulse_src(4'b1000);
        repeat (6) tick();
        check("nest_low_int_n", 32'(bus.int_n), 32'(1));
        check("nest_low_pend",  32'(bus.pend),  32'(4'b1000));
        reti_pulse();
        wait_int("nest_low_int");
        ack_cycle(8'h14, 1'b1, "nest_ch3");
        reti_pulse();

        // Masking and clear-beats-event.
        set_mask(0, 1'b1);
        pulse_src(4'b0001);
        repeat (6) tick();
        check("mask_pend",  32'(bus.pend),  32'(0));
        check("mask_int_n", 32'(bus.int_n), 32'(1));
        set_mask(0, 1'b0);
        bus.src = 4'b0001;
        tick();
        bus.src = '0;
        tick();
        bus.clr = 4'b0001;
        tick();
        bus.clr = '0;
        repeat (4) tick();
        check("clr_pend",  32'(bus.pend),  32'(0));
        check("clr_int_n", 32'(bus.int_n), 32'(1));

        // Daisy chain.
        bus.iei = 1'b0;
        pulse_src(4'b0010);
        repeat (6) tick();
        check("iei0_int_n", 32'(bus.int_n), 32'(1));
        check("iei0_pend",  32'(bus.pend),  32'(4'b0010));
        check("iei0_ieo",   32'(bus.ieo),   32'(0));
        bus.iei = 1'b1;
        wait_int("iei1_int");
        ack_cycle(8'h10, 1'b1, "daisy_ack");
        check("isv_ieo", 32'(bus.ieo), 32'(0));
        reti_pulse();
        check("reti_ieo", 32'(bus.ieo), 32'(1));
        ack_cycle(8'h00, 1'b0, "ack_none");

        // Asynchronous reset in the middle of an acknowledge.
        pulse_src(4'b0010);
        wait_int("rst_ack_int");
        bus.m1_n = 1'b0;
        bus.iorq_n = 1'b0;
        tick();
        check("pre_rst_oe", 32'(bus.vec_oe), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_oe",    32'(bus.vec_oe), 32'(0));
        check("async_int_n", 32'(bus.int_n),  32'(1));
        check("async_pend",  32'(bus.pend),   32'(0));
        bus.m1_n = 1'b1;
        bus.iorq_n = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        pulse_src(4'b1111);
        repeat (6) tick();
        check("rerst_mask_pend", 32'(bus.pend), 32'(0));
        for (int c = 0; c < NCH; c++) set_mask(c, 1'b0);

        // Random traffic against the model.
        ack_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            bus.src     = 4'($urandom) & 4'($urandom);
            bus.msk_we  = ($urandom_range(15) == 0) ? 4'(1) << $urandom_range(3) : 4'b0;
            bus.msk_din = ($urandom_range(3) == 0);
            bus.clr     = ($urandom_range(7) == 0) ? 4'($urandom) : 4'b0;
            bus.reti    = ($urandom_range(11) == 0);
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) begin
                    bus.m1_n = 1'b1;
                    bus.iorq_n = 1'b1;
                end
            end else if ($urandom_range(5) == 0) begin
                bus.m1_n   = 1'b0;
                bus.iorq_n = 1'b0;
                bus.iei    = 1'b1;
                ack_cnt    = 1 + $urandom_range(3);
            end else begin
                bus.iei = ($urandom_range(7) != 0);
            end
            tick();
        end
        bus.src = '0; bus.msk_we = '0; bus.clr = '0; bus.reti = 1'b0;
        bus.m1_n = 1'b1; bus.iorq_n = 1'b1; bus.iei = 1'b1;
        repeat (4) tick();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
